iomem_ram_arbiter: RTL and testbench
====================================

Name: iomem_ram_arbiter

Overview:
- Shares the single 128-bit main-memory port between two iomem requesters: m0 (CPU) and m1 (program loader / DMA).
- Performs round-robin arbitration, latches the winning request and drives one RAM access.
- Models the RAM's fixed access latency, then returns one ready pulse with read data to the winner.
- Sits between the requesters and the block RAM, replacing ad-hoc ready/shift-register logic at top level.

Parameters:
- BLOCK_SIZE, 128, data width of iomem and RAM ports (bits)
- NUMS_BYTE, BLOCK_SIZE/8, byte-strobe width
- RAM_DELAY, 16, cycles spent in ACCESS per transaction (must be >= 2)
- RAM_DEPTH, 8192, RAM lines; RAM address width AW = $clog2(RAM_DEPTH)
- RAM_BASE_ADDR, 32'h8000_0000, base of RAM region
- RAM_MASK_ADDR, 32'h000f_ffff, RAM region mask; hit = (addr & ~mask) == base

Ports:
- clk_o  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- m0_valid / m1_valid  in  1  request valid
- m0_addr / m1_addr  in  32  byte address
- m0_wstrb / m1_wstrb  in  NUMS_BYTE  byte write strobes; all-zero = read
- m0_wdata / m1_wdata  in  BLOCK_SIZE  write data
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  BLOCK_SIZE  read data, valid while ready is high
- m0_err / m1_err  out  1  decode-miss flag, coincident with ready
- ram_addr  out  AW  line address = latched addr[AW+3:4]
- ram_wdata  out  BLOCK_SIZE  write data to RAM
- ram_wstrb  out  NUMS_BYTE  write strobes to RAM
- ram_rd_en  out  1  read enable to RAM
- ram_rdata  in  BLOCK_SIZE  RAM read data, 1-cycle latency after ram_rd_en
- busy_o  out  1  high whenever state != IDLE
- grant_o  out  1  index of current/last granted master

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset values: state = IDLE; all ready, err, ram_wstrb and ram_rd_en = 0; rdata registers = 0; busy_o = 0; last_grant = 1, so m0 wins the first tie; counter = 0.
- IDLE, arbitration:
  - Only one valid high: grant it.
  - Both high: grant !last_grant.
  - On grant (cycle T), latch master index, addr, wstrb, wdata.
  - Granted addr hits RAM region: go to ACCESS with cnt = 0.
  - Decode miss: go to RESP with rdata = 0 and err = 1; no RAM strobe is issued.
- ACCESS, first cycle (cnt = 0):
  - Latched wstrb != 0: ram_wstrb = latched wstrb, ram_rd_en = 0.
  - Latched wstrb == 0: ram_rd_en = 1.
  - ram_wstrb and ram_rd_en are zero on every other cycle; ram_addr and ram_wdata hold the latched values for the whole ACCESS state.
- ACCESS, data capture: at cnt = 1, capture ram_rdata into the response register (reads only; writes return 0).
- ACCESS, exit: cnt increments each cycle; at cnt == RAM_DELAY-1, go to RESP.
- RESP:
  - Granted master sees ready = 1, rdata = captured value, err as latched, for exactly one cycle.
  - The other master's ready/err stay 0.
  - last_grant <= granted index; return to IDLE.
- Latency:
  - RAM hit: ready at T+RAM_DELAY+1.
  - Decode miss: ready at T+1.
  - Next grant can occur on the cycle after RESP, so back-to-back throughput is one transaction per RAM_DELAY+2 cycles.
- Requester protocol: valid, addr, wstrb and wdata stay stable until ready.
- Valid dropped mid-transaction: the transaction still completes and the ready pulse is still emitted.
- A request arriving while busy waits; there is no queueing beyond the valid line itself.
- Fairness: with both masters continuously valid, grants strictly alternate.
- Reset asserted mid-transaction: on the next edge, return to IDLE with reset values; no ready pulse; any RAM write already strobed is not undone.
- Boundary: RAM_DELAY < 2 is unsupported; flag with an elaboration-time check.

Decomposition:
- Shared package (iomem_pkg): BLOCK_SIZE, NUMS_BYTE, BYTE_OFFSET = 4, RAM_BASE_ADDR, RAM_MASK_ADDR, FSM state encoding, and a ram_hit(addr) function reused by the top-level wrapper.
- One natural sub-module: rr_arbiter2, the 2-way round-robin grant logic taking valid[1:0] and last_grant and producing grant and grant_idx.
- FSM, counter and datapath latches stay in iomem_ram_arbiter.

Test Plan:
- Single read, m0, addr 0x8000_0010, RAM line 1 = 0xA5 pattern, RAM_DELAY = 16: ram_rd_en pulses once with ram_addr = 1; m0_ready at T+17 with m0_rdata = pattern; m1_ready stays 0.
- Single write, m1, addr 0x8000_0020, wstrb 16'h000F, wdata 0x...DEADBEEF: ram_wstrb = 000F for exactly one cycle with ram_addr = 2; m1_ready at T+17; a follow-up read returns DEADBEEF in bytes 0-3.
- Simultaneous valids from reset, both held: grant order m0, m1, m0, m1; ready pulses spaced 18 cycles apart.
- Decode miss, m0 addr 0x2000_0000: m0_ready and m0_err at T+1, rdata 0; ram_wstrb and ram_rd_en never asserted.
- rst_n pulled low at cnt = 5 of an m1 read: busy_o = 0 the next cycle; no m1_ready; the next m0/m1 tie grants m0.
- m0 drops valid at cnt = 3: m0_ready still pulses at T+17, then the FSM returns to IDLE.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem <-> block RAM path.
// Holds the bus geometry, the RAM region decode constants, the arbiter FSM
// state encoding and the RAM region hit test used by the arbiter top.
package iomem_pkg;

  localparam int BLOCK_SIZE  = 128;
  localparam int NUMS_BYTE   = BLOCK_SIZE / 8;
  // Byte address bits below the 128-bit line address.
  localparam int BYTE_OFFSET = 4;

  localparam logic [31:0] RAM_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] RAM_MASK_ADDR = 32'h000f_ffff;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // True when the byte address falls inside the RAM window.
  function automatic logic ram_hit(input logic [31:0] addr);
    return (addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic.
// Ports:
//   valid[1:0]  request lines from master 0 and master 1
//   last_grant  index of the master granted most recently
//   grant       at least one request is present
//   grant_idx   index of the master that wins this cycle
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_idx
);

  // A lone requester always wins; on a tie the master that did not win
  // last time gets the port, so continuous requesters alternate.
  always_comb begin
    grant     = |valid;
    grant_idx = 1'b0;
    if (valid == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (valid[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/iomem_ram_arbiter.sv
// Shares one 128-bit block RAM port between two iomem requesters
// (m0 = CPU, m1 = program loader / DMA). A winning request is latched,
// one RAM strobe is issued, the fixed RAM latency is counted out and a
// single ready pulse with read data is returned to the winner. Addresses
// outside the RAM window complete immediately with err set.
// Ports:
//   clk_o, rst_n                       clock, synchronous active-low reset
//   mX_valid/addr/wstrb/wdata          requester X request (wstrb 0 = read)
//   mX_ready/rdata/err                 requester X one-cycle completion
//   ram_addr/wdata/wstrb/rd_en         RAM command, live during ACCESS
//   ram_rdata                          RAM read data, 1 cycle after rd_en
//   busy_o                             a transaction is in flight
//   grant_o                            current / last granted master
module iomem_ram_arbiter
  import iomem_pkg::*;
#(
  parameter int RAM_DELAY = 16,
  parameter int RAM_DEPTH = 8192,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                  clk_o,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  input  logic [31:0]           m0_addr,
  input  logic [NUMS_BYTE-1:0]  m0_wstrb,
  input  logic [BLOCK_SIZE-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic [BLOCK_SIZE-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_valid,
  input  logic [31:0]           m1_addr,
  input  logic [NUMS_BYTE-1:0]  m1_wstrb,
  input  logic [BLOCK_SIZE-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic [BLOCK_SIZE-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [AW-1:0]         ram_addr,
  output logic [BLOCK_SIZE-1:0] ram_wdata,
  output logic [NUMS_BYTE-1:0]  ram_wstrb,
  output logic                  ram_rd_en,
  input  logic [BLOCK_SIZE-1:0] ram_rdata,
  output logic                  busy_o,
  output logic                  grant_o
);

  localparam int CW = $clog2(RAM_DELAY);

  // The capture at cnt = 1 and the exit at RAM_DELAY-1 need at least two
  // ACCESS cycles.
  if (RAM_DELAY < 2) begin : g_bad_ram_delay
    $error("iomem_ram_arbiter: RAM_DELAY must be at least 2");
  end

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  grant_idx_q, grant_idx_d;
  logic                  last_grant_q, last_grant_d;
  logic [AW-1:0]         line_q, line_d;
  logic [NUMS_BYTE-1:0]  wstrb_q, wstrb_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  arb_grant;
  logic                  arb_idx;
  logic [31:0]           sel_addr;
  logic [NUMS_BYTE-1:0]  sel_wstrb;
  logic [BLOCK_SIZE-1:0] sel_wdata;
  logic                  resp_active;

  rr_arbiter2 u_rr_arbiter2 (
    .valid      ({m1_valid, m0_valid}),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign sel_addr  = arb_idx ? m1_addr  : m0_addr;
  assign sel_wstrb = arb_idx ? m1_wstrb : m0_wstrb;
  assign sel_wdata = arb_idx ? m1_wdata : m0_wdata;

  // State and datapath registers; reset leaves last_grant at 1 so that
  // m0 wins the first tie.
  always_ff @(posedge clk_o) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_idx_q  <= 1'b0;
      last_grant_q <= 1'b1;
      line_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      line_q       <= line_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Next-state and RAM command logic. The RAM strobe is only driven on the
  // first ACCESS cycle so each transaction touches the RAM exactly once.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    line_d       = line_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    ram_wstrb    = '0;
    ram_rd_en    = 1'b0;
    resp_active  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_grant) begin
          grant_idx_d = arb_idx;
          line_d      = sel_addr[AW+BYTE_OFFSET-1:BYTE_OFFSET];
          wstrb_d     = sel_wstrb;
          wdata_d     = sel_wdata;
          cnt_d       = '0;
          rdata_d     = '0;
          if (ram_hit(sel_addr)) begin
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          if (wstrb_q != '0) begin
            ram_wstrb = wstrb_q;
          end else begin
            ram_rd_en = 1'b1;
          end
        end
        // RAM data appears one cycle after the read strobe.
        if (cnt_q == CW'(1) && wstrb_q == '0) begin
          rdata_d = ram_rdata;
        end
        if (cnt_q == CW'(RAM_DELAY - 1)) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        resp_active  = 1'b1;
        last_grant_d = grant_idx_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_addr  = line_q;
  assign ram_wdata = wdata_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign grant_o   = grant_idx_q;

  assign m0_ready = resp_active && !grant_idx_q;
  assign m1_ready = resp_active &&  grant_idx_q;
  assign m0_err   = m0_ready && err_q;
  assign m1_err   = m1_ready && err_q;
  assign m0_rdata = m0_ready ? rdata_q : '0;
  assign m1_rdata = m1_ready ? rdata_q : '0;

endmodule

// File: tb/tb_iomem_ram_arbiter.sv
// Self-checking bench for iomem_ram_arbiter.
// A behavioural RAM sits on the RAM port. A transaction-level model
// predicts, from the arbitration and latency rules, which master completes
// on which cycle and with what data; a compare process checks every cycle
// and directed scenarios pin the model with hand-computed values.
module tb_iomem_ram_arbiter;

  localparam int RAM_DELAY = 16;
  localparam int DEPTH     = 8192;

  logic         clk_o = 1'b0;
  logic         rst_n = 1'b0;
  logic         m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0]  m0_addr = '0, m1_addr = '0;
  logic [15:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [127:0] m0_wdata = '0, m1_wdata = '0;
  logic         m0_ready, m1_ready, m0_err, m1_err;
  logic [127:0] m0_rdata, m1_rdata;
  logic [12:0]  ram_addr;
  logic [127:0] ram_wdata;
  logic [15:0]  ram_wstrb;
  logic         ram_rd_en;
  logic [127:0] ram_rdata;
  logic         busy_o, grant_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_o = ~clk_o;

  iomem_ram_arbiter #(.RAM_DELAY(RAM_DELAY), .RAM_DEPTH(DEPTH)) dut (
    .clk_o     (clk_o),
    .rst_n     (rst_n),
    .m0_valid  (m0_valid),
    .m0_addr   (m0_addr),
    .m0_wstrb  (m0_wstrb),
    .m0_wdata  (m0_wdata),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_valid  (m1_valid),
    .m1_addr   (m1_addr),
    .m1_wstrb  (m1_wstrb),
    .m1_wdata  (m1_wdata),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wstrb (ram_wstrb),
    .ram_rd_en (ram_rd_en),
    .ram_rdata (ram_rdata),
    .busy_o    (busy_o),
    .grant_o   (grant_o)
  );

  function automatic logic [127:0] preset_line(input int i);
    if (i == 1) return {16{8'hA5}};
    return 128'(i);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit m, input logic v, input logic [31:0] a,
                               input logic [15:0] s, input logic [127:0] d);
    if (m) begin
      m1_valid = v; m1_addr = a; m1_wstrb = s; m1_wdata = d;
    end else begin
      m0_valid = v; m0_addr = a; m0_wstrb = s; m0_wdata = d;
    end
  endtask

  // Behavioural RAM: one-cycle read latency, byte-strobed writes.
  logic [127:0] ram_mem [0:DEPTH-1];
  bit ram_loaded = 1'b0;
  always @(posedge clk_o) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= preset_line(i);
      ram_loaded <= 1'b1;
      ram_rdata  <= '0;
    end else begin
      if (ram_rd_en) ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 16; b++)
        if (ram_wstrb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Transaction model: edge counter n; a grant on edge g completes in the
  // cycle after edge r (g + RAM_DELAY on a hit, g on a miss).
  logic [127:0] model_mem [0:DEPTH-1];
  int           n = 0, g = 0, r = 0, idle_from = 0;
  bit           pend = 0, win = 0, last_g = 1, hit_m = 0, is_wr = 0, err_m = 0;
  logic [15:0]  ws_m;
  logic [127:0] wd_m, dat_m;
  logic [12:0]  line_m;

  always @(posedge clk_o) begin
    logic [31:0]  a;
    logic [15:0]  s;
    logic [127:0] d;
    n = n + 1;
    if (n == 1) for (int i = 0; i < DEPTH; i++) model_mem[i] = preset_line(i);
    if (!rst_n) begin
      pend = 0; last_g = 1; idle_from = n;
    end else begin
      if (pend && n == r + 1) begin
        pend = 0; last_g = win; idle_from = n;
      end
      if (!pend && n - 1 >= idle_from && (m0_valid || m1_valid)) begin
        win    = (m0_valid && m1_valid) ? !last_g : m1_valid;
        a      = win ? m1_addr  : m0_addr;
        s      = win ? m1_wstrb : m0_wstrb;
        d      = win ? m1_wdata : m0_wdata;
        hit_m  = (a[31:20] == 12'h800);
        line_m = 13'((a >> 4) & 32'h1FFF);
        is_wr  = (s != 16'h0);
        ws_m   = s; wd_m = d; g = n; pend = 1;
        if (!hit_m) begin
          r = n; dat_m = '0; err_m = 1;
        end else begin
          r = n + RAM_DELAY; err_m = 0; dat_m = '0;
          if (is_wr) begin
            for (int b = 0; b < 16; b++)
              if (s[b]) model_mem[line_m][8*b +: 8] = d[8*b +: 8];
          end else begin
            dat_m = model_mem[line_m];
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus strobe counters.
  int          rd_pulses = 0, wr_pulses = 0;
  logic [12:0] last_rd_addr = '0, last_wr_addr = '0;
  always @(negedge clk_o) begin
    bit resp;
    if (n >= 1) begin
      resp = pend && (n == r);
      checkOutput("busy_o", busy_o, pend);
      checkOutput("m0_ready", m0_ready, resp && !win);
      checkOutput("m1_ready", m1_ready, resp && win);
      checkOutput("m0_err", m0_err, resp && !win && err_m);
      checkOutput("m1_err", m1_err, resp && win && err_m);
      if (resp) checkOutput("rdata", win ? m1_rdata : m0_rdata, dat_m);
      checkOutput("ram_rd_en", ram_rd_en, pend && hit_m && !is_wr && n == g);
      checkOutput("ram_wstrb", ram_wstrb, (pend && hit_m && is_wr && n == g) ? ws_m : 16'h0);
      if (pend) checkOutput("grant_o", grant_o, win);
      if (pend && hit_m && n < r) begin
        checkOutput("ram_addr", ram_addr, line_m);
        checkOutput("ram_wdata", ram_wdata, wd_m);
      end
      if (ram_rd_en === 1'b1) begin rd_pulses++; last_rd_addr = ram_addr; end
      if (ram_wstrb != 16'h0) begin wr_pulses++; last_wr_addr = ram_addr; end
    end
  end

  task automatic wait_ready(input bit m, input int max_cycles, output int cycles,
                            output logic [127:0] data, output logic err);
    bit seen = 0;
    cycles = 0; data = '0; err = 0;
    for (int i = 1; i <= max_cycles && !seen; i++) begin
      @(negedge clk_o);
      if ((m ? m1_ready : m0_ready) === 1'b1) begin
        seen = 1; cycles = i;
        data = m ? m1_rdata : m0_rdata;
        err  = m ? m1_err : m0_err;
      end
    end
    if (!seen) checkOutput("ready_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_any(input int max_cycles, output int cycles, output int who);
    who = -1; cycles = 0;
    for (int i = 1; i <= max_cycles && who < 0; i++) begin
      @(negedge clk_o);
      if (m0_ready === 1'b1) begin who = 0; cycles = i; end
      else if (m1_ready === 1'b1) begin who = 1; cycles = i; end
    end
    if (who < 0) checkOutput("any_ready_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    int           cyc, cyc2, who;
    logic [127:0] data;
    logic         err;

    // Reset values.
    repeat (3) @(negedge clk_o);
    checkOutput("reset_busy", busy_o, 1'b0);
    checkOutput("reset_m0_ready", m0_ready, 1'b0);
    checkOutput("reset_rd_en", ram_rd_en, 1'b0);
    checkOutput("reset_wstrb", ram_wstrb, 16'h0);
    rst_n = 1'b1;

    // Single read by m0 from line 1.
    @(negedge clk_o);
    applyStimulus(0, 1, 32'h8000_0010, 16'h0, '0);
    wait_ready(0, 40, cyc, data, err);
    applyStimulus(0, 0, 32'h0, 16'h0, '0);
    checkOutput("read_latency", cyc, 17);
    checkOutput("read_data", data, {16{8'hA5}});
    checkOutput("read_err", err, 1'b0);
    checkOutput("read_rd_pulses", rd_pulses, 1);
    checkOutput("read_rd_addr", last_rd_addr, 13'd1);

    // Single write by m1 to line 2, then read it back.
    @(negedge clk_o);
    applyStimulus(1, 1, 32'h8000_0020, 16'h000F, 128'hDEADBEEF);
    wait_ready(1, 40, cyc, data, err);
    applyStimulus(1, 0, 32'h0, 16'h0, '0);
    checkOutput("write_latency", cyc, 17);
    checkOutput("write_wr_pulses", wr_pulses, 1);
    checkOutput("write_wr_addr", last_wr_addr, 13'd2);
    @(negedge clk_o);
    applyStimulus(1, 1, 32'h8000_0020, 16'h0, '0);
    wait_ready(1, 40, cyc, data, err);
    applyStimulus(1, 0, 32'h0, 16'h0, '0);
    checkOutput("readback_low", data[31:0], 32'hDEADBEEF);
    checkOutput("readback_high", data[127:32], 96'h0);

    // Decode miss completes next cycle with err and no RAM strobe.
    @(negedge clk_o);
    applyStimulus(0, 1, 32'h2000_0000, 16'h0, '0);
    wait_ready(0, 10, cyc, data, err);
    applyStimulus(0, 0, 32'h0, 16'h0, '0);
    checkOutput("miss_latency", cyc, 1);
    checkOutput("miss_err", err, 1'b1);
    checkOutput("miss_data", data, 128'h0);
    checkOutput("miss_rd_pulses", rd_pulses, 2);
    checkOutput("miss_wr_pulses", wr_pulses, 1);

    // m0 drops valid at cnt = 3; the transaction still completes.
    @(negedge clk_o);
    applyStimulus(0, 1, 32'h8000_0030, 16'h0, '0);
    repeat (4) @(negedge clk_o);
    applyStimulus(0, 0, 32'h0, 16'h0, '0);
    wait_ready(0, 40, cyc2, data, err);
    checkOutput("drop_latency", cyc2 + 4, 17);
    checkOutput("drop_data", data, 128'd3);
    @(negedge clk_o);
    checkOutput("drop_idle", busy_o, 1'b0);

    // Reset at cnt = 5 of an m1 read; the following tie goes to m0.
    applyStimulus(1, 1, 32'h8000_0040, 16'h0, '0);
    repeat (6) @(negedge clk_o);
    rst_n = 1'b0;
    applyStimulus(0, 1, 32'h8000_0030, 16'h0, '0);
    @(negedge clk_o);
    checkOutput("midrst_busy", busy_o, 1'b0);
    checkOutput("midrst_m1_ready", m1_ready, 1'b0);
    rst_n = 1'b1;

    // Both held: grants alternate m0, m1, m0, m1, 18 cycles apart.
    for (int k = 0; k < 4; k++) begin
      wait_any(40, cyc, who);
      checkOutput("fair_order", who, k % 2);
      checkOutput("fair_spacing", cyc, (k == 0) ? 17 : 18);
    end
    applyStimulus(0, 0, 32'h0, 16'h0, '0);
    applyStimulus(1, 0, 32'h0, 16'h0, '0);

    repeat (3) @(negedge clk_o);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
